difftest_aia_event_gen: RTL and testbench

- Upstream feeder of the per-core AIA difftest DPI sink.
- Watches the live AIA CSR snapshot every cycle: mtopei, stopei, vstopei and hgeip.
- When any field differs from the last reported snapshot, it queues an event.
- It drains one event per accepted cycle, driving the sink's valid/enable and payload ports.
- A small FIFO absorbs bursts while the downstream DPI batching stage deasserts ready.

---
 rtl/difftest_aia_pkg.sv | 17 +
 rtl/aia_event_fifo.sv | 84 ++++++++
 rtl/difftest_aia_event_gen.sv | 105 ++++++++++
 tb/tb_difftest_aia_event_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/difftest_aia_pkg.sv
// Shared types for the AIA difftest event path.
//   aia_event_t : one AIA CSR snapshot (mtopei, stopei, vstopei, hgeip).
//   AIA_EVT_W   : packed width of aia_event_t.
//   COREID_W    : width of the static core id.
package difftest_aia_pkg;

    localparam int AIA_EVT_W = 256;
    localparam int COREID_W  = 8;

    typedef struct packed {
        logic [63:0] mtopei;
        logic [63:0] stopei;
        logic [63:0] vstopei;
        logic [63:0] hgeip;
    } aia_event_t;

endpackage

// File: rtl/aia_event_fifo.sv
// Register FIFO of DEPTH aia_event_t entries.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears storage too)
//   push_i        : write din_i at the tail (caller only pushes when not full
//                   or when popping in the same cycle)
//   pop_i         : drop the head entry (caller only pops when not empty)
//   ovr_i         : overwrite the newest entry with din_i (no pointer motion);
//                   only driven by the top when DIFFTEST_AIA_COALESCE_EN is set
//   din_i, dout_o : write data, head entry
//   full_o,empty_o: occupancy flags
module aia_event_fifo
    import difftest_aia_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       ovr_i,
    input  aia_event_t din_i,
    output aia_event_t dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    aia_event_t       mem_q [DEPTH];
    aia_event_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] tail_idx;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Newest entry sits one slot behind the write pointer.
        tail_idx = wr_ptr_q - PTR_W'(1);

        if (push_i) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else if (ovr_i) begin
            mem_d[tail_idx] = din_i;
        end

        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/difftest_aia_event_gen.sv
// Detects changes in the live AIA CSR snapshot and queues one event per
// change for the per-core AIA difftest sink.
// Ports:
//   clock, reset           : core clock, synchronous active-high reset
//   io_in_*                : live mtopei/stopei/vstopei/hgeip
//   io_coreid              : static core id, passed to io_out_coreid
//   io_out_ready           : downstream accepts the head event this cycle
//   io_out_valid, enable   : head present / head consumed this cycle
//   io_out_*               : head event payload (registered)
//   io_stall_cnt           : saturating count of cycles a change could not be
//                            queued (or, with coalescing, was merged into the tail)
// Build option: DIFFTEST_AIA_COALESCE_EN merges a change into the newest
// entry when the FIFO is full instead of holding it pending.
module difftest_aia_event_gen
    import difftest_aia_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [63:0]         io_in_mtopei,
    input  logic [63:0]         io_in_stopei,
    input  logic [63:0]         io_in_vstopei,
    input  logic [63:0]         io_in_hgeip,
    input  logic [COREID_W-1:0] io_coreid,
    input  logic                io_out_ready,
    output logic                io_out_valid,
    output logic                enable,
    output logic [63:0]         io_out_mtopei,
    output logic [63:0]         io_out_stopei,
    output logic [63:0]         io_out_vstopei,
    output logic [63:0]         io_out_hgeip,
    output logic [COREID_W-1:0] io_out_coreid,
    output logic [CNT_W-1:0]    io_stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    aia_event_t       snap, head;
    aia_event_t       shadow_q, shadow_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             change, push, pop, ovr;
    logic             fifo_full, fifo_empty;

    assign snap   = {io_in_mtopei, io_in_stopei, io_in_vstopei, io_in_hgeip};
    assign change = (snap != shadow_q);
    assign pop    = !fifo_empty && io_out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push   = change && (!fifo_full || pop);

`ifdef DIFFTEST_AIA_COALESCE_EN
    assign ovr = change && fifo_full && !pop;
`else
    assign ovr = 1'b0;
`endif

    always_comb begin
        shadow_d = shadow_q;
        // Shadow follows only what was actually recorded; an unrecorded
        // change stays visible and is retried next cycle.
        if (push || ovr) begin
            shadow_d = snap;
        end
        // change && !push is exactly the stall cycle, or the coalesce cycle
        // when merging is enabled.
        stall_d = (change && !push) ? sat_inc(stall_q) : stall_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q <= '0;
            stall_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            stall_q  <= stall_d;
        end
    end

    aia_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop),
        .ovr_i   (ovr),
        .din_i   (snap),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign io_out_valid   = !fifo_empty;
    assign enable         = pop;
    assign io_out_mtopei  = head.mtopei;
    assign io_out_stopei  = head.stopei;
    assign io_out_vstopei = head.vstopei;
    assign io_out_hgeip   = head.hgeip;
    assign io_out_coreid  = io_coreid;
    assign io_stall_cnt   = stall_q;

endmodule

// File: tb/tb_difftest_aia_event_gen.sv
module tb_difftest_aia_event_gen;
    import difftest_aia_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_m = '0, in_s = '0, in_v = '0, in_h = '0;
    logic [7:0]  coreid = 8'h5A;
    logic        ready = 1'b1;

    logic        out_valid, out_enable;
    logic [63:0] out_m, out_s, out_v, out_h;
    logic [7:0]  out_coreid;
    logic [15:0] stall_cnt;

    always #5 clock = ~clock;

    difftest_aia_event_gen #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_in_mtopei   (in_m),
        .io_in_stopei   (in_s),
        .io_in_vstopei  (in_v),
        .io_in_hgeip    (in_h),
        .io_coreid      (coreid),
        .io_out_ready   (ready),
        .io_out_valid   (out_valid),
        .enable         (out_enable),
        .io_out_mtopei  (out_m),
        .io_out_stopei  (out_s),
        .io_out_vstopei (out_v),
        .io_out_hgeip   (out_h),
        .io_out_coreid  (out_coreid),
        .io_stall_cnt   (stall_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: a queue of reported snapshots, the last reported
    // snapshot, and the stall count.
    aia_event_t  mq[$];
    aia_event_t  m_shadow;
    logic [15:0] m_stall;
    bit          model_on = 0;
    aia_event_t  m_snap;
    bit          m_pop;

    always @(posedge clock) begin
        m_snap = {in_m, in_s, in_v, in_h};
        if (reset) begin
            mq.delete();
            m_shadow = '0;
            m_stall  = '0;
            model_on = 1;
        end else if (model_on) begin
            m_pop = (mq.size() > 0) && ready;
            if (m_pop) void'(mq.pop_front());
            if (m_snap != m_shadow) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(m_snap);
                    m_shadow = m_snap;
                end else begin
`ifdef DIFFTEST_AIA_COALESCE_EN
                    mq[mq.size()-1] = m_snap;
                    m_shadow = m_snap;
`endif
                    if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus capture of consumed hgeip.
    logic [63:0] cap[$];

    always @(negedge clock) begin
        if (model_on) begin
            check("valid", out_valid, mq.size() > 0);
            check("enable", out_enable, (mq.size() > 0) && ready);
            check("stall_cnt", stall_cnt, m_stall);
            check("coreid", out_coreid, coreid);
            if (mq.size() > 0)
                check("payload", {out_m, out_s, out_v, out_h}, mq[0]);
            if (out_enable) cap.push_back(out_h);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [63:0] exp_q[$];

    task automatic check_cap(input string name);
        check({name, "_count"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check(name, (i < cap.size()) ? cap[i] : 64'hDEAD_DEAD_DEAD_DEAD, exp_q[i]);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        check("rst_valid", out_valid, 1'b0);
        check("rst_enable", out_enable, 1'b0);
        check("rst_stall", stall_cnt, 16'd0);
        check("rst_payload", {out_m, out_s, out_v, out_h}, 256'd0);

        // Idle: all zero inputs never produce an event
        repeat (20) tick();
        check("idle_valid", out_valid, 1'b0);
        check("idle_stall", stall_cnt, 16'd0);

        // Single change, empty FIFO, one-cycle latency
        cap.delete();
        in_m = 64'h0000_0000_0021_0021;
        tick();
        check("single_valid", out_valid, 1'b1);
        check("single_enable", out_enable, 1'b1);
        check("single_mtopei", out_m, 64'h210021);
        check("single_others", {out_s, out_v, out_h}, 192'd0);
        tick();
        check("single_drained", out_valid, 1'b0);
        repeat (2) tick();
        check("single_one_event", cap.size(), 1);

        // Burst of five hgeip changes with ready low
        ready = 1'b0;
        cap.delete();
        for (int i = 1; i <= 5; i++) begin
            in_h = 64'(i);
            tick();
        end
        check("burst_stall", stall_cnt, 16'd1);
        check("burst_head", out_h, 64'd1);
        ready = 1'b1;
        repeat (7) tick();
`ifdef DIFFTEST_AIA_COALESCE_EN
        exp_q = '{64'd1, 64'd2, 64'd3, 64'd5};
`else
        exp_q = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
`endif
        check_cap("burst_order");
        check("burst_stall_after", stall_cnt, 16'd1);

        // Full FIFO, pop and push in the same cycle
        ready = 1'b0;
        for (int i = 10; i <= 13; i++) begin
            in_h = 64'(i);
            tick();
        end
        check("full_head", out_h, 64'd10);
        cap.delete();
        ready = 1'b1;
        in_h  = 64'd14;
        tick();
        check("fullpp_valid", out_valid, 1'b1);
        check("fullpp_head", out_h, 64'd11);
        check("fullpp_stall", stall_cnt, 16'd1);
        ready = 1'b0;
        tick();
        check("hold_head", out_h, 64'd11);
        check("hold_valid", out_valid, 1'b1);
        ready = 1'b1;
        repeat (6) tick();
        exp_q = '{64'd10, 64'd11, 64'd12, 64'd13, 64'd14};
        check_cap("fullpp_order");

        // Reset mid-operation discards queued events
        ready = 1'b0;
        for (int i = 20; i <= 22; i++) begin
            in_h = 64'(i);
            tick();
        end
        check("pre_rst_valid", out_valid, 1'b1);
        reset = 1'b1;
        tick();
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_stall", stall_cnt, 16'd0);
        check("midrst_payload", {out_m, out_s, out_v, out_h}, 256'd0);
        reset = 1'b0;
        tick();
        check("rereport_valid", out_valid, 1'b1);
        check("rereport_hgeip", out_h, 64'd22);
        check("rereport_mtopei", out_m, 64'h210021);

        // stopei / vstopei fields
        ready = 1'b1;
        tick();
        check("drain_empty", out_valid, 1'b0);
        in_s = 64'hDEAD_BEEF_0000_0001;
        in_v = 64'h0000_0003_0000_0007;
        tick();
        check("sv_valid", out_valid, 1'b1);
        check("sv_stopei", out_s, 64'hDEAD_BEEF_0000_0001);
        check("sv_vstopei", out_v, 64'h0000_0003_0000_0007);
        check("sv_hgeip", out_h, 64'd22);
        repeat (3) tick();
        check("final_empty", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
